// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
// Optional feature macro: RESET_SEQ_ACK_EN (per-domain acknowledge handshake).
package reset_seq_pkg;

    typedef enum logic [2:0] {
        HOLD,
        COUNT,
        RELEASE,
        WAIT_ACK,
        DONE,
        SOFT
    } seq_state_t;

    // Bits needed to hold values 0..delay without wrapping.
    function automatic int unsigned timer_width(input int unsigned delay);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < (64'(delay) + 64'd1)) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable saturating down-counter with a one-cycle terminal-count pulse.
// tc fires once per load, in the cycle where the count has reached zero.
module rst_seq_timer #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;
    logic             armed_q;

    assign tc = armed_q && (count_q == '0);

    // Count down to zero and stop there; a load re-arms the terminal pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            armed_q <= 1'b0;
        end else if (load) begin
            count_q <= load_val;
            armed_q <= 1'b1;
        end else begin
            if (count_q != '0) begin
                count_q <= count_q - WIDTH'(1);
            end
            if (tc) begin
                armed_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: frees NUM_DOMAINS reset outputs in ascending order,
// STAGE_DELAY cycles apart, with a synchronous soft-reset path.
// Optional feature macro: RESET_SEQ_ACK_EN adds domain_ack handshaking.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS = 4,
    parameter int unsigned STAGE_DELAY = 16
) (
    input  logic                   clk,
    input  logic                   rst_n_in,
    input  logic                   sw_rst_req,
`ifdef RESET_SEQ_ACK_EN
    input  logic [NUM_DOMAINS-1:0] domain_ack,
`endif
    output logic [NUM_DOMAINS-1:0] rst_n_out,
    output logic                   seq_done
);

    localparam int unsigned     TW       = timer_width(STAGE_DELAY);
    localparam int unsigned     IW       = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    // Loading DELAY-1 makes tc land exactly DELAY edges after the load edge.
    localparam logic [TW-1:0]   LOAD_VAL = TW'(STAGE_DELAY - 1);
    localparam logic [IW-1:0]   LAST_IDX = IW'(NUM_DOMAINS - 1);

    seq_state_t             state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] out_q, out_d;
    logic                   done_q, done_d;
    logic                   tmr_load;
    logic                   tmr_tc;
    logic                   do_release;

    rst_seq_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n_in),
        .load     (tmr_load),
        .load_val (LOAD_VAL),
        .tc       (tmr_tc)
    );

    // State, index and output registers; hard reset forces everything low.
    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= HOLD;
            idx_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    // Next-state and output computation; soft reset overrides every state.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        out_d      = out_q;
        done_d     = done_q;
        tmr_load   = 1'b0;
        do_release = 1'b0;

        if (sw_rst_req) begin
            state_d  = SOFT;
            idx_d    = '0;
            out_d    = '0;
            done_d   = 1'b0;
            tmr_load = 1'b1;
        end else begin
            case (state_q)
                HOLD: begin
                    state_d  = COUNT;
                    tmr_load = 1'b1;
                end
                COUNT: begin
                    do_release = tmr_tc;
                end
                // RELEASE also honours tc so STAGE_DELAY=1 keeps one release per edge.
                RELEASE: begin
                    if (&out_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (tmr_tc) begin
                        do_release = 1'b1;
                    end else begin
                        state_d = COUNT;
                    end
                end
`ifdef RESET_SEQ_ACK_EN
                WAIT_ACK: begin
                    if (domain_ack[idx_q]) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = RELEASE;
                        end else begin
                            idx_d    = idx_q + IW'(1);
                            state_d  = COUNT;
                            tmr_load = 1'b1;
                        end
                    end
                end
`endif
                DONE: begin
                    done_d = 1'b1;
                end
                SOFT: begin
                    if (tmr_tc) begin
                        state_d  = COUNT;
                        tmr_load = 1'b1;
                    end
                end
                default: begin
                    state_d = HOLD;
                end
            endcase
        end

        if (do_release) begin
            out_d[idx_q] = 1'b1;
`ifdef RESET_SEQ_ACK_EN
            state_d = WAIT_ACK;
`else
            state_d = RELEASE;
            if (idx_q != LAST_IDX) begin
                idx_d    = idx_q + IW'(1);
                tmr_load = 1'b1;
            end
`endif
        end
    end

    assign rst_n_out = out_q;
    assign seq_done  = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed self-checking bench for reset_sequencer (default and minimal configs).
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n_in = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic [3:0] rst_n_out;
    logic       seq_done;

    logic       rst1_n = 1'b0;
    logic       sw1 = 1'b0;
    logic [0:0] min_out;
    logic       min_done;

`ifdef RESET_SEQ_ACK_EN
    logic [3:0] ack_vec = '1;
    logic [0:0] ack_min = '1;
`endif

    int tests = 0;
    int fails = 0;
    int edge_n = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_DOMAINS (4),
        .STAGE_DELAY (16)
    ) dut (
        .clk        (clk),
        .rst_n_in   (rst_n_in),
        .sw_rst_req (sw_rst_req),
`ifdef RESET_SEQ_ACK_EN
        .domain_ack (ack_vec),
`endif
        .rst_n_out  (rst_n_out),
        .seq_done   (seq_done)
    );

    reset_sequencer #(
        .NUM_DOMAINS (1),
        .STAGE_DELAY (1)
    ) dut_min (
        .clk        (clk),
        .rst_n_in   (rst1_n),
        .sw_rst_req (sw1),
`ifdef RESET_SEQ_ACK_EN
        .domain_ack (ack_min),
`endif
        .rst_n_out  (min_out),
        .seq_done   (min_done)
    );

    task automatic goto_edge(input int target);
        while (edge_n < target) begin
            @(posedge clk);
            edge_n++;
        end
        #1;
    endtask

    task automatic start_seq();
        @(negedge clk);
        rst_n_in   = 1'b0;
        sw_rst_req = 1'b0;
        @(negedge clk);
        rst_n_in = 1'b1;
        @(posedge clk);
        edge_n = 0;
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (rst_n_out !== 4'b0000 || seq_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: rst_n_out=%b seq_done=%b, expected 0000/0", rst_n_out, seq_done);
        end
        repeat (20) @(posedge clk);
        #1;
        tests++;
        if (rst_n_out !== 4'b0000 || seq_done !== 1'b0 || min_out !== 1'b0 || min_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_held: rst_n_out=%b seq_done=%b min=%b/%b, expected 0000/0 0/0",
                     rst_n_out, seq_done, min_out, min_done);
        end
    endtask

    task automatic test_sequence();
        int         e_tab [8] = '{15, 16, 31, 32, 48, 63, 64, 65};
        logic [3:0] o_tab [8] = '{4'b0000, 4'b0001, 4'b0001, 4'b0011, 4'b0111, 4'b0111, 4'b1111, 4'b1111};
        logic       d_tab [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        start_seq();
        for (int i = 0; i < 8; i++) begin
            goto_edge(e_tab[i]);
            tests++;
            if (rst_n_out !== o_tab[i] || seq_done !== d_tab[i]) begin
                fails++;
                $display("FAIL sequence@%0d: rst_n_out=%b seq_done=%b, expected %b/%b",
                         e_tab[i], rst_n_out, seq_done, o_tab[i], d_tab[i]);
            end
        end
    endtask

    task automatic test_soft();
        int         e_tab [8] = '{100, 101, 116, 117, 132, 133, 181, 182};
        logic [3:0] o_tab [8] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b1111, 4'b1111};
        logic       d_tab [8] = '{1, 0, 0, 0, 0, 0, 0, 1};
        for (int i = 0; i < 8; i++) begin
            goto_edge(e_tab[i]);
            tests++;
            if (rst_n_out !== o_tab[i] || seq_done !== d_tab[i]) begin
                fails++;
                $display("FAIL soft@%0d: rst_n_out=%b seq_done=%b, expected %b/%b",
                         e_tab[i], rst_n_out, seq_done, o_tab[i], d_tab[i]);
            end
            if (e_tab[i] == 100) sw_rst_req = 1'b1;
            if (e_tab[i] == 101) sw_rst_req = 1'b0;
        end
    endtask

    task automatic test_hard_abort();
        int         e_tab [4] = '{15, 16, 64, 65};
        logic [3:0] o_tab [4] = '{4'b0000, 4'b0001, 4'b1111, 4'b1111};
        logic       d_tab [4] = '{0, 0, 0, 1};
        start_seq();
        goto_edge(40);
        tests++;
        if (rst_n_out !== 4'b0011 || seq_done !== 1'b0) begin
            fails++;
            $display("FAIL abort_pre: rst_n_out=%b seq_done=%b, expected 0011/0", rst_n_out, seq_done);
        end
        #2 rst_n_in = 1'b0;
        #1;
        tests++;
        if (rst_n_out !== 4'b0000 || seq_done !== 1'b0) begin
            fails++;
            $display("FAIL abort_async: rst_n_out=%b seq_done=%b, expected 0000/0", rst_n_out, seq_done);
        end
        start_seq();
        for (int i = 0; i < 4; i++) begin
            goto_edge(e_tab[i]);
            tests++;
            if (rst_n_out !== o_tab[i] || seq_done !== d_tab[i]) begin
                fails++;
                $display("FAIL abort_restart@%0d: rst_n_out=%b seq_done=%b, expected %b/%b",
                         e_tab[i], rst_n_out, seq_done, o_tab[i], d_tab[i]);
            end
        end
    endtask

    task automatic test_soft_retime();
        int         e_tab [4] = '{31, 53, 62, 63};
        logic [3:0] o_tab [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001};
        start_seq();
        goto_edge(20);
        sw_rst_req = 1'b1;
        goto_edge(21);
        sw_rst_req = 1'b0;
        goto_edge(30);
        sw_rst_req = 1'b1;
        goto_edge(31);
        sw_rst_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            goto_edge(e_tab[i]);
            tests++;
            if (rst_n_out !== o_tab[i] || seq_done !== 1'b0) begin
                fails++;
                $display("FAIL retime@%0d: rst_n_out=%b seq_done=%b, expected %b/0",
                         e_tab[i], rst_n_out, seq_done, o_tab[i]);
            end
        end
    endtask

    task automatic test_soft_held();
        int         e_tab [4] = '{80, 105, 121, 122};
        logic [3:0] o_tab [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001};
        goto_edge(70);
        tests++;
        if (rst_n_out !== 4'b0001 || seq_done !== 1'b0) begin
            fails++;
            $display("FAIL held_pre: rst_n_out=%b seq_done=%b, expected 0001/0", rst_n_out, seq_done);
        end
        sw_rst_req = 1'b1;
        goto_edge(90);
        sw_rst_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            goto_edge(e_tab[i]);
            tests++;
            if (rst_n_out !== o_tab[i] || seq_done !== 1'b0) begin
                fails++;
                $display("FAIL held@%0d: rst_n_out=%b seq_done=%b, expected %b/0",
                         e_tab[i], rst_n_out, seq_done, o_tab[i]);
            end
        end
    endtask

    task automatic test_min_config();
        int         e_tab [8] = '{0, 1, 2, 10, 11, 12, 13, 14};
        logic [0:0] o_tab [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic       d_tab [8] = '{0, 0, 1, 1, 0, 0, 0, 1};
        @(negedge clk);
        rst1_n = 1'b1;
        @(posedge clk);
        edge_n = 0;
        #1;
        for (int i = 0; i < 8; i++) begin
            goto_edge(e_tab[i]);
            tests++;
            if (min_out !== o_tab[i] || min_done !== d_tab[i]) begin
                fails++;
                $display("FAIL min@%0d: rst_n_out=%b seq_done=%b, expected %b/%b",
                         e_tab[i], min_out, min_done, o_tab[i], d_tab[i]);
            end
            if (e_tab[i] == 10) sw1 = 1'b1;
            if (e_tab[i] == 11) sw1 = 1'b0;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, expected bench completion");
        $fatal(1, "bench time limit");
    end

    initial begin
        test_reset();
        test_sequence();
        test_soft();
        test_hard_abort();
        test_soft_retime();
        test_soft_held();
        test_min_config();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
